flash_core_wb_bridge: RTL

//  Converts the core data port (req/gnt/rvalid protocol) into the single-outstanding wishbone

---
 rtl/flash_core_wb_bridge.sv | 95 +++++++++
 1 files changed

// File: rtl/flash_core_wb_bridge.sv
// Core data port (req/gnt/rvalid) to single-outstanding wishbone bridge for the flash interface.
// One transaction at a time: IDLE -> BUS (cyc held until ack or timeout) -> RESP (one rvalid pulse).
module flash_core_wb_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF,
   parameter logic [31:0] ADDR_MASK      = 32'h000F_FFFF
) (
   input  logic        clk_int,
   input  logic        rstn_int,
   input  logic        i_system_rdy,
   input  logic        data_req_i,
   output logic        data_gnt_o,
   input  logic [31:0] data_addr_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   output logic [31:0] o_wb_adr,
   output logic        o_wb_cyc,
   output logic        o_wb_we,
   output logic [31:0] o_wb_data,
   input  logic [31:0] i_wb_data,
   input  logic        i_wb_ack
);
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;

   assign data_gnt_o = (state == IDLE) & data_req_i & i_system_rdy;

   always_ff @(posedge clk_int or negedge rstn_int) begin
      if (!rstn_int) begin
         state         <= IDLE;
         cnt           <= '0;
         data_rvalid_o <= 1'b0;
         data_rdata_o  <= '0;
         data_err_o    <= 1'b0;
         o_wb_adr      <= '0;
         o_wb_cyc      <= 1'b0;
         o_wb_we       <= 1'b0;
         o_wb_data     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (data_gnt_o) begin
                  // Partial writes cannot be expressed on this bus; answer with an error locally.
                  if (!data_we_i || data_be_i == 4'hF) begin
                     o_wb_adr  <= data_addr_i & ADDR_MASK & 32'hFFFF_FFFC;
                     o_wb_we   <= data_we_i;
                     o_wb_data <= data_wdata_i;
                     o_wb_cyc  <= 1'b1;
                     cnt       <= '0;
                     state     <= BUS;
                  end else begin
                     data_rdata_o  <= ERR_RDATA;
                     data_err_o    <= 1'b1;
                     data_rvalid_o <= 1'b1;
                     state         <= RESP;
                  end
               end
            end
            BUS: begin
               // Ack wins over an expiry landing in the same cycle.
               if (i_wb_ack) begin
                  o_wb_cyc      <= 1'b0;
                  data_rdata_o  <= o_wb_we ? 32'h0 : i_wb_data;
                  data_err_o    <= 1'b0;
                  data_rvalid_o <= 1'b1;
                  state         <= RESP;
               end else if (cnt == CNT_LAST) begin
                  o_wb_cyc      <= 1'b0;
                  data_rdata_o  <= ERR_RDATA;
                  data_err_o    <= 1'b1;
                  data_rvalid_o <= 1'b1;
                  state         <= RESP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RESP: begin
               data_rvalid_o <= 1'b0;
               cnt           <= '0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
